// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - opcodes and result constants shared by the alu16 block
package alu16_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_EQ   = 4'hA;
    localparam logic [3:0] OP_GT   = 4'hB;
    localparam logic [3:0] OP_LT   = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_SHL  = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Compare results are distinct codes so the controller can tell which test fired.
    localparam logic [1:0] CMP_EQ_RES = 2'd1;
    localparam logic [1:0] CMP_GT_RES = 2'd2;
    localparam logic [1:0] CMP_LT_RES = 2'd3;

endpackage

// File: rtl/alu16_reg_if.sv
// rtl/alu16_reg_if.sv - operand, function and result bundle between controller and ALU
interface alu16_reg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_FUN;
    logic [WIDTH-1:0] ALU_OUT;
    logic             Arith_Flag;
    logic             Logic_Flag;
    logic             CMP_Flag;
    logic             Shift_Flag;

    modport master (
        output A, B, ALU_FUN,
        input  ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
    );

    modport slave (
        input  A, B, ALU_FUN,
        output ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
    );
endinterface

// File: rtl/alu16_flag_decode.sv
// rtl/alu16_flag_decode.sv - combinational one-hot operation class decode
module alu16_flag_decode
    import alu16_pkg::*;
(
    input  logic [3:0] alu_fun,
    output logic       arith_flag,
    output logic       logic_flag,
    output logic       cmp_flag,
    output logic       shift_flag
);

    // OP_NOP falls outside every range, leaving all four flags low.
    always_comb begin
        arith_flag = (alu_fun <= OP_DIV);
        logic_flag = (alu_fun >= OP_AND) && (alu_fun <= OP_XNOR);
        cmp_flag   = (alu_fun >= OP_EQ)  && (alu_fun <= OP_LT);
        shift_flag = (alu_fun >= OP_SHR) && (alu_fun <= OP_SHL);
    end

endmodule

// File: rtl/alu16_reg.sv
// rtl/alu16_reg.sv - 16-bit unsigned ALU with registered result and class flags
module alu16_reg
    import alu16_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic        CLK,
    input  logic        RST,
    alu16_reg_if.slave  bus
);

    logic [WIDTH-1:0] result;

    always_comb begin
        result = '0;
        case (bus.ALU_FUN)
            OP_ADD:  result = bus.A + bus.B;
            OP_SUB:  result = bus.A - bus.B;
            OP_MUL:  result = bus.A * bus.B;
            // Divide by zero is defined as zero rather than left to the divider.
            OP_DIV:  result = (bus.B == '0) ? '0 : (bus.A / bus.B);
            OP_AND:  result = bus.A & bus.B;
            OP_OR:   result = bus.A | bus.B;
            OP_NAND: result = ~(bus.A & bus.B);
            OP_NOR:  result = ~(bus.A | bus.B);
            OP_XOR:  result = bus.A ^ bus.B;
            OP_XNOR: result = ~(bus.A ^ bus.B);
            OP_EQ:   result = (bus.A == bus.B) ? WIDTH'(CMP_EQ_RES) : '0;
            OP_GT:   result = (bus.A >  bus.B) ? WIDTH'(CMP_GT_RES) : '0;
            OP_LT:   result = (bus.A <  bus.B) ? WIDTH'(CMP_LT_RES) : '0;
            OP_SHR:  result = bus.A >> 1;
            OP_SHL:  result = bus.A << 1;
            default: result = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bus.ALU_OUT <= '0;
        end else begin
            bus.ALU_OUT <= result;
        end
    end

    alu16_flag_decode u_flag_decode (
        .alu_fun    (bus.ALU_FUN),
        .arith_flag (bus.Arith_Flag),
        .logic_flag (bus.Logic_Flag),
        .cmp_flag   (bus.CMP_Flag),
        .shift_flag (bus.Shift_Flag)
    );

endmodule

// File: tb/tb_alu16_reg.sv
// tb/tb_alu16_reg.sv - randomized and directed self-checking bench for alu16_reg
module tb_alu16_reg;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [15:0] exp_out;
    bit          exp_valid;

    alu16_reg_if #(.WIDTH(16)) bus ();

    alu16_reg #(.WIDTH(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_result(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        longint ua;
        longint ub;
        ua = longint'(a);
        ub = longint'(b);
        case (f)
            4'h0: return 16'((ua + ub) % 65536);
            4'h1: return 16'((ua - ub + 65536) % 65536);
            4'h2: return 16'((ua * ub) % 65536);
            4'h3: return (ub == 0) ? 16'h0000 : 16'(ua / ub);
            4'h4: return a & b;
            4'h5: return a | b;
            4'h6: return ~(a & b);
            4'h7: return ~(a | b);
            4'h8: return a ^ b;
            4'h9: return ~(a ^ b);
            4'hA: return (ua == ub) ? 16'd1 : 16'd0;
            4'hB: return (ua > ub) ? 16'd2 : 16'd0;
            4'hC: return (ua < ub) ? 16'd3 : 16'd0;
            4'hD: return 16'(ua / 2);
            4'hE: return 16'((ua * 2) % 65536);
            default: return 16'h0000;
        endcase
    endfunction

    // {Arith, Logic, CMP, Shift}
    function automatic logic [3:0] ref_flags(input logic [3:0] f);
        int v;
        v = int'(f);
        if (v < 4)  return 4'b1000;
        if (v < 10) return 4'b0100;
        if (v < 13) return 4'b0010;
        if (v < 15) return 4'b0001;
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        exp_out   = (!rst) ? 16'h0000 : ref_result(bus.ALU_FUN, bus.A, bus.B);
        exp_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            tests++;
            if (bus.ALU_OUT !== exp_out) begin
                fails++;
                $display("FAIL model_out fun=%h a=%h b=%h got=%h want=%h",
                         bus.ALU_FUN, bus.A, bus.B, bus.ALU_OUT, exp_out);
            end
        end
        tests++;
        if ({bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag} !== ref_flags(bus.ALU_FUN)) begin
            fails++;
            $display("FAIL model_flags fun=%h got=%b want=%b", bus.ALU_FUN,
                     {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}, ref_flags(bus.ALU_FUN));
        end
    end

    task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        #2;
        bus.ALU_FUN = f;
        bus.A       = a;
        bus.B       = b;
    endtask

    task automatic step(input string name, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] want, input logic [3:0] want_flags);
        drive(f, a, b);
        @(posedge clk);
        #1;
        tests++;
        if (bus.ALU_OUT !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, bus.ALU_OUT, want);
        end
        tests++;
        if ({bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag} !== want_flags) begin
            fails++;
            $display("FAIL %s_flags got=%b want=%b", name,
                     {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}, want_flags);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        exp_out   = 16'h0000;
        exp_valid = 1'b0;
        rst       = 1'b0;
        bus.ALU_FUN = 4'h0;
        bus.A       = 16'd5;
        bus.B       = 16'd5;

        step("reset", 4'h0, 16'd5, 16'd5, 16'h0000, 4'b1000);
        rst = 1'b1;
        step("reset_release", 4'h0, 16'd5, 16'd5, 16'h000A, 4'b1000);

        step("add", 4'h0, 16'd3, 16'd13, 16'h0010, 4'b1000);
        step("add_wrap", 4'h0, 16'hFFFF, 16'd1, 16'h0000, 4'b1000);
        step("sub", 4'h1, 16'd3, 16'd2, 16'h0001, 4'b1000);
        step("sub_wrap", 4'h1, 16'd0, 16'd1, 16'hFFFF, 4'b1000);
        step("mul", 4'h2, 16'd2, 16'd1, 16'h0002, 4'b1000);
        step("mul_big", 4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1000);
        step("div", 4'h3, 16'd6, 16'd2, 16'h0003, 4'b1000);
        step("div_zero", 4'h3, 16'd6, 16'd0, 16'h0000, 4'b1000);

        step("and",  4'h4, 16'h0003, 16'h000D, 16'h0001, 4'b0100);
        step("or",   4'h5, 16'h0003, 16'h000D, 16'h000F, 4'b0100);
        step("nand", 4'h6, 16'h0003, 16'h000D, 16'hFFFE, 4'b0100);
        step("nor",  4'h7, 16'h0003, 16'h000D, 16'hFFF0, 4'b0100);
        step("xor",  4'h8, 16'h0003, 16'h000D, 16'h000E, 4'b0100);
        step("xnor", 4'h9, 16'h0003, 16'h000D, 16'hFFF1, 4'b0100);

        step("eq_true",  4'hA, 16'd3, 16'd3, 16'h0001, 4'b0010);
        step("eq_false", 4'hA, 16'd3, 16'd4, 16'h0000, 4'b0010);
        step("gt_true",  4'hB, 16'd7, 16'd1, 16'h0002, 4'b0010);
        step("gt_false", 4'hB, 16'd1, 16'd7, 16'h0000, 4'b0010);
        step("lt_true",  4'hC, 16'd3, 16'd4, 16'h0003, 4'b0010);
        step("lt_false", 4'hC, 16'd4, 16'd3, 16'h0000, 4'b0010);

        step("shr",     4'hD, 16'd3, 16'hFFFF, 16'h0001, 4'b0001);
        step("shl",     4'hE, 16'd3, 16'hFFFF, 16'h0006, 4'b0001);
        step("shl_msb", 4'hE, 16'h8001, 16'd0, 16'h0002, 4'b0001);
        step("nop",     4'hF, 16'd3, 16'd1, 16'h0000, 4'b0000);

        // Inputs change mid-cycle: result must hold, flags must follow at once.
        step("lat_setup", 4'h0, 16'd3, 16'd4, 16'h0007, 4'b1000);
        bus.ALU_FUN = 4'h8;
        bus.A       = 16'h00F0;
        bus.B       = 16'h000F;
        #1;
        tests++;
        if (bus.ALU_OUT !== 16'h0007) begin
            fails++;
            $display("FAIL latency_hold got=%h want=%h", bus.ALU_OUT, 16'h0007);
        end
        tests++;
        if ({bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag} !== 4'b0100) begin
            fails++;
            $display("FAIL latency_flags got=%b want=%b",
                     {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}, 4'b0100);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.ALU_OUT !== 16'h00FF) begin
            fails++;
            $display("FAIL latency_update got=%h want=%h", bus.ALU_OUT, 16'h00FF);
        end

        for (int i = 0; i < 600; i++) begin
            logic [3:0]  f;
            logic [15:0] a;
            logic [15:0] b;
            f = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 16'h0000 :
                ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
            drive(f, a, b);
            rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
        end
        drive(4'h0, 16'd1, 16'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu16_reg.md
Name: alu16_reg

Overview:
- 16-bit unsigned ALU with a registered result.
- Covers arithmetic (add, sub, mul, div), bitwise logic, compare and 1-bit shift operations, selected by a 4-bit function code.
- The result updates once per clock edge. Four one-hot class flags report which class of operation is selected.
- Used as a standalone datapath block driven by a controller that presents operands and a function code each cycle.

Parameters:
- WIDTH, 16, operand and result width; all behaviour below assumes 16.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-low reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- ALU_FUN  input  4  function select.
- ALU_OUT  output  WIDTH  registered result.
- Arith_Flag  output  1  high when ALU_FUN is 0x0–0x3.
- Logic_Flag  output  1  high when ALU_FUN is 0x4–0x9.
- CMP_Flag  output  1  high when ALU_FUN is 0xA–0xC.
- Shift_Flag  output  1  high when ALU_FUN is 0xD–0xE.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-low.
- Reset: when RST=0 at a rising CLK edge, ALU_OUT <= 0. Reset overrides any operation in flight.
- Latency: ALU_OUT takes the value computed from the A/B/ALU_FUN sampled at a rising edge and holds it until the next edge. Latency is 1 cycle and there is no handshake.
- Opcode decode, result loaded into ALU_OUT (all unsigned):
  - 0x0 ADD: A+B, truncated to 16 bits; carry discarded.
  - 0x1 SUB: A−B modulo 2^16.
  - 0x2 MUL: low 16 bits of A*B.
  - 0x3 DIV: A/B, integer quotient. B=0 yields 0x0000.
  - 0x4 AND: A&B.
  - 0x5 OR: A|B.
  - 0x6 NAND: ~(A&B).
  - 0x7 NOR: ~(A|B).
  - 0x8 XOR: A^B.
  - 0x9 XNOR: ~(A^B).
  - 0xA EQ: 0x0001 if A==B, else 0x0000.
  - 0xB GT: 0x0002 if A>B, else 0x0000.
  - 0xC LT: 0x0003 if A<B, else 0x0000.
  - 0xD SHR: A>>1, logical (zero fill); B is ignored.
  - 0xE SHL: A<<1, zero fill, MSB discarded; B is ignored.
  - 0xF: 0x0000.
- Flags:
  - Purely combinational decode of the current ALU_FUN; they are not registered and not affected by RST.
  - Exactly one flag is high for 0x0–0xE; all four are low for 0xF.
- No X propagation: every opcode and every operand value, including B=0, produces a defined result.

Decomposition:
- Shared package alu16_pkg: opcode localparams (OP_ADD … OP_SHL, OP_NOP=4'hF) and the compare result constants (1, 2, 3).
- One natural sub-module, alu16_flag_decode: combinational mapping from ALU_FUN to the four flags.
- Result mux and output register stay in the top.

Test Plan:
- Reset: RST=0 for one edge with ALU_FUN=0x0, A=5, B=5 -> ALU_OUT=0x0000. Release reset, next edge -> ALU_OUT=0x000A.
- Arithmetic:
  - ADD A=3, B=13 -> 0x0010; ADD 0xFFFF+1 -> 0x0000.
  - SUB 3−2 -> 0x0001; SUB 0−1 -> 0xFFFF.
  - MUL 2*1 -> 0x0002.
  - DIV 6/2 -> 0x0003; DIV 6/0 -> 0x0000.
  - Arith_Flag=1 and other flags 0 throughout.
- Logic with A=0x0003, B=0x000D: AND -> 0x0001, OR -> 0x000F, NAND -> 0xFFFE, NOR -> 0xFFF0, XOR -> 0x000E, XNOR -> 0xFFF1. Logic_Flag=1 throughout.
- Compare:
  - EQ 3,3 -> 0x0001; EQ 3,4 -> 0x0000.
  - GT 7,1 -> 0x0002; GT 1,7 -> 0x0000.
  - LT 3,4 -> 0x0003.
  - CMP_Flag=1 throughout.
- Shift and default:
  - SHR A=3 -> 0x0001; SHL A=3 -> 0x0006; SHL 0x8001 -> 0x0002. Shift_Flag=1.
  - ALU_FUN=0xF, A=3, B=1 -> 0x0000 with all flags 0.
- Latency: change ALU_FUN and operands between edges. Required: ALU_OUT holds its old value until the next rising edge, while the flags follow ALU_FUN immediately.
